// File: rtl/ppu_vblank_nmi_gen_if.sv
// CPU register-bus bundle for the PPU vblank/NMI block.
// The CPU side drives address, data and strobes; the PPU returns registered read data.
interface ppu_vblank_nmi_gen_if;
   localparam int unsigned ADDR_W = 16;
   localparam int unsigned DATA_W = 8;

   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_data_in;
   logic              cpu_write_en;
   logic              cpu_read_en;
   logic [DATA_W-1:0] cpu_data_out;

   modport master (
      output cpu_addr, cpu_data_in, cpu_write_en, cpu_read_en,
      input  cpu_data_out
   );

   modport slave (
      input  cpu_addr, cpu_data_in, cpu_write_en, cpu_read_en,
      output cpu_data_out
   );
endinterface

// File: rtl/ppu_vblank_nmi_gen.sv
// PPU dot/scanline timing, PPUCTRL/PPUMASK/PPUSTATUS registers and edge-latched vblank NMI.
// Optional: define PPU_ODD_FRAME_SKIP_EN to drop one pre-render dot on odd rendering frames.
module ppu_vblank_nmi_gen #(
   parameter int unsigned DOTS_PER_LINE   = 341,
   parameter int unsigned LINES_PER_FRAME = 262,
   parameter int unsigned VBLANK_LINE     = 241
) (
   input  logic                      clk,
   input  logic                      rst,
   ppu_vblank_nmi_gen_if.slave       bus,
   input  logic                      i_dot_ce,
   input  logic                      i_halt,
   input  logic                      i_sprite0_hit,
   input  logic                      i_sprite_overflow,
   input  logic                      i_toggle_set,
   input  logic                      i_nmi_ack,
   output logic [7:0]                o_ppu_status,
   output logic [7:0]                o_ppu_ctrl1,
   output logic [7:0]                o_ppu_ctrl2,
   output logic                      o_write_toggle,
   output logic [8:0]                o_dot,
   output logic [8:0]                o_scanline,
   output logic                      o_frame_odd,
   output logic                      o_nmi_req
);
   localparam int unsigned CNT_W  = 9;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned OB_W   = 5;
   localparam logic [CNT_W-1:0] LAST_DOT  = CNT_W'(DOTS_PER_LINE - 1);
   localparam logic [CNT_W-1:0] LAST_LINE = CNT_W'(LINES_PER_FRAME - 1);
   localparam logic [CNT_W-1:0] VBL_LINE  = CNT_W'(VBLANK_LINE);

   logic [CNT_W-1:0]  r_dot;
   logic [CNT_W-1:0]  r_scanline;
   logic              r_frame_odd;
   logic              r_vblank;
   logic              r_sprite0;
   logic              r_overflow;
   logic [OB_W-1:0]   r_open_bus;
   logic [DATA_W-1:0] r_ctrl1;
   logic [DATA_W-1:0] r_ctrl2;
   logic [DATA_W-1:0] r_data_out;
   logic              r_write_toggle;
   logic              r_nmi_line_d;
   logic              r_nmi_req;

   logic              w_decode;
   logic              w_wr;
   logic              w_rd;
   logic              w_rd_status;
   logic              w_skip;
   logic              w_dot_wrap;
   logic              w_frame_wrap;
   logic [CNT_W-1:0]  w_dot_nxt;
   logic [CNT_W-1:0]  w_line_nxt;
   logic              w_vbl_set;
   logic              w_flag_clr;
   logic [DATA_W-1:0] w_status;
   logic              w_nmi_line;
   logic              w_nmi_edge;

   // Bus decode, counter next-state and event detection.
   always_comb begin
      w_decode    = (bus.cpu_addr[15:13] == 3'b001) && (bus.cpu_addr[2:0] <= 3'd2);
      w_wr        = bus.cpu_write_en & w_decode;
      w_rd        = bus.cpu_read_en & w_decode;
      w_rd_status = w_rd && (bus.cpu_addr[2:0] == 3'd2);
`ifdef PPU_ODD_FRAME_SKIP_EN
      w_skip      = r_frame_odd && (r_ctrl2[3] | r_ctrl2[4]) &&
                    (r_scanline == LAST_LINE) && (r_dot == LAST_DOT - CNT_W'(1));
`else
      w_skip      = 1'b0;
`endif
      w_dot_wrap   = (r_dot == LAST_DOT) || w_skip;
      w_frame_wrap = w_dot_wrap && (r_scanline == LAST_LINE);
      w_dot_nxt    = w_dot_wrap ? '0 : r_dot + CNT_W'(1);
      w_line_nxt   = r_scanline;
      if (w_frame_wrap)
         w_line_nxt = '0;
      else if (w_dot_wrap)
         w_line_nxt = r_scanline + CNT_W'(1);
      // Both events fire on the dot_ce that moves the counter from dot 0 to dot 1.
      w_vbl_set  = i_dot_ce && (r_scanline == VBL_LINE)  && (r_dot == '0);
      w_flag_clr = i_dot_ce && (r_scanline == LAST_LINE) && (r_dot == '0);
      w_status   = {r_vblank, r_sprite0, r_overflow, r_open_bus};
      w_nmi_line = r_vblank & r_ctrl1[7];
      w_nmi_edge = w_nmi_line & ~r_nmi_line_d;
   end

   // Dot/scanline/frame counters.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_dot       <= '0;
         r_scanline  <= '0;
         r_frame_odd <= 1'b0;
      end else if (!i_halt && i_dot_ce) begin
         r_dot      <= w_dot_nxt;
         r_scanline <= w_line_nxt;
         if (w_frame_wrap)
            r_frame_odd <= ~r_frame_odd;
      end
   end

   // CPU-visible registers and read data.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ctrl1    <= '0;
         r_ctrl2    <= '0;
         r_open_bus <= '0;
         r_data_out <= '0;
      end else if (!i_halt) begin
         if (w_wr) begin
            r_open_bus <= bus.cpu_data_in[OB_W-1:0];
            if (bus.cpu_addr[2:0] == 3'd0)
               r_ctrl1 <= bus.cpu_data_in;
            else if (bus.cpu_addr[2:0] == 3'd1)
               r_ctrl2 <= bus.cpu_data_in;
         end
         if (w_rd)
            r_data_out <= w_rd_status ? w_status : {3'b000, r_open_bus};
      end
   end

   // Status flags and write toggle; pre-render clear beats a status read, which beats the vblank set.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_vblank       <= 1'b0;
         r_sprite0      <= 1'b0;
         r_overflow     <= 1'b0;
         r_write_toggle <= 1'b0;
      end else if (!i_halt) begin
         if (w_flag_clr || w_rd_status)
            r_vblank <= 1'b0;
         else if (w_vbl_set)
            r_vblank <= 1'b1;
         if (w_flag_clr) begin
            r_sprite0  <= 1'b0;
            r_overflow <= 1'b0;
         end else begin
            if (i_sprite0_hit)
               r_sprite0 <= 1'b1;
            if (i_sprite_overflow)
               r_overflow <= 1'b1;
         end
         if (w_rd_status)
            r_write_toggle <= 1'b0;
         else if (i_toggle_set)
            r_write_toggle <= ~r_write_toggle;
      end
   end

   // NMI edge detector; a fresh edge wins over a coincident acknowledge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_nmi_line_d <= 1'b0;
         r_nmi_req    <= 1'b0;
      end else if (!i_halt) begin
         r_nmi_line_d <= w_nmi_line;
         if (w_nmi_edge)
            r_nmi_req <= 1'b1;
         else if (i_nmi_ack)
            r_nmi_req <= 1'b0;
      end
   end

   assign bus.cpu_data_out = r_data_out;
   assign o_ppu_status     = w_status;
   assign o_ppu_ctrl1      = r_ctrl1;
   assign o_ppu_ctrl2      = r_ctrl2;
   assign o_write_toggle   = r_write_toggle;
   assign o_dot            = r_dot;
   assign o_scanline       = r_scanline;
   assign o_frame_odd      = r_frame_odd;
   assign o_nmi_req        = r_nmi_req;
endmodule
